// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the 4x4 matrix keypad scanner.
//   db_state_e  - debounce FSM states
//   scan_res_e  - classification of one complete four-row scan
//   key_label() - raw matrix index (row*4+col) to the hex legend on the keycap
package keypad_pkg;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      PRESS_CHK   = 2'd1,
      DOWN        = 2'd2,
      RELEASE_CHK = 2'd3
   } db_state_e;

   typedef enum logic [1:0] {
      NONE   = 2'd0,
      SINGLE = 2'd1,
      MULTI  = 2'd2
   } scan_res_e;

   // Pmod KYPD legend: row0 = 1 2 3 A, row1 = 4 5 6 B, row2 = 7 8 9 C, row3 = 0 F E D
   function automatic logic [3:0] key_label(input logic [3:0] raw);
      logic [3:0] lbl;
      case (raw)
         4'd0:    lbl = 4'h1;
         4'd1:    lbl = 4'h2;
         4'd2:    lbl = 4'h3;
         4'd3:    lbl = 4'hA;
         4'd4:    lbl = 4'h4;
         4'd5:    lbl = 4'h5;
         4'd6:    lbl = 4'h6;
         4'd7:    lbl = 4'hB;
         4'd8:    lbl = 4'h7;
         4'd9:    lbl = 4'h8;
         4'd10:   lbl = 4'h9;
         4'd11:   lbl = 4'hC;
         4'd12:   lbl = 4'h0;
         4'd13:   lbl = 4'hF;
         4'd14:   lbl = 4'hE;
         4'd15:   lbl = 4'hD;
         default: lbl = 4'h0;
      endcase
      return lbl;
   endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: decoded key stream from the scanner to its consumer.
//   key_code  - hex label of the last accepted key
//   key_valid - one-cycle strobe on acceptance
//   key_down  - accepted key still held
//   multi_key - last completed scan saw two or more keys
// master = scanner (drives), slave = controller/datapath (reads).
interface keypad_scanner_if;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_down;
   logic       multi_key;

   modport master (output key_code, output key_valid, output key_down, output multi_key);
   modport slave  (input  key_code, input  key_valid, input  key_down, input  multi_key);
endinterface

// File: rtl/keypad_debounce.sv
// keypad_debounce: accepts a press after DEBOUNCE_SCANS identical single-key
// scans and a release after DEBOUNCE_SCANS empty scans.
//   clk, reset - clock, asynchronous active-high reset
//   scan_done  - one-cycle strobe: scan_res/raw_idx describe a completed scan
//   scan_res   - NONE / SINGLE / MULTI
//   raw_idx    - row*4+col of the single key (meaningful for SINGLE only)
//   key_code   - label of the last accepted key, held until the next press
//   key_valid  - one-cycle pulse on acceptance
//   key_down   - high from acceptance until release is accepted
module keypad_debounce
   import keypad_pkg::*;
#(
   parameter int unsigned DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scan_done,
   input  scan_res_e  scan_res,
   input  logic [3:0] raw_idx,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_down
);

   localparam int unsigned   CW       = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_SCANS);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

   db_state_e     state_r, state_s;
   logic [CW-1:0] cnt_r, cnt_s, cnt_inc_s;
   logic [3:0]    cand_r, cand_s;
   logic [3:0]    key_code_r, key_code_s;
   logic          key_valid_r, key_valid_s;
   logic          key_down_r, key_down_s;

   // State, counter and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= IDLE;
         cnt_r       <= CNT_ZERO;
         cand_r      <= 4'h0;
         key_code_r  <= 4'h0;
         key_valid_r <= 1'b0;
         key_down_r  <= 1'b0;
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         cand_r      <= cand_s;
         key_code_r  <= key_code_s;
         key_valid_r <= key_valid_s;
         key_down_r  <= key_down_s;
      end
   end

   // Next state; only a completed scan can move the FSM
   always_comb begin
      state_s     = state_r;
      cnt_s       = cnt_r;
      cand_s      = cand_r;
      key_code_s  = key_code_r;
      key_valid_s = 1'b0;
      key_down_s  = key_down_r;
      cnt_inc_s   = cnt_r + CNT_ONE;
      if (scan_done) begin
         case (state_r)
            IDLE: begin
               if (scan_res == SINGLE) begin
                  state_s = PRESS_CHK;
                  cand_s  = raw_idx;
                  cnt_s   = CNT_ONE;
               end else begin
                  cnt_s = CNT_ZERO;
               end
            end
            PRESS_CHK: begin
               if ((scan_res == SINGLE) && (raw_idx == cand_r)) begin
                  if (cnt_inc_s == CNT_DONE) begin
                     state_s     = DOWN;
                     cnt_s       = CNT_ZERO;
                     key_code_s  = key_label(cand_r);
                     key_valid_s = 1'b1;
                     key_down_s  = 1'b1;
                  end else begin
                     cnt_s = cnt_inc_s;
                  end
               end else if (scan_res == SINGLE) begin
                  // a different key restarts the qualification
                  cand_s = raw_idx;
                  cnt_s  = CNT_ONE;
               end else begin
                  state_s = IDLE;
                  cnt_s   = CNT_ZERO;
               end
            end
            DOWN: begin
               // extra keys while held are ignored: no roll-over, no repeat
               if (scan_res == NONE) begin
                  state_s = RELEASE_CHK;
                  cnt_s   = CNT_ONE;
               end else begin
                  state_s = DOWN;
               end
            end
            RELEASE_CHK: begin
               if (scan_res == NONE) begin
                  if (cnt_inc_s == CNT_DONE) begin
                     state_s    = IDLE;
                     cnt_s      = CNT_ZERO;
                     key_down_s = 1'b0;
                  end else begin
                     cnt_s = cnt_inc_s;
                  end
               end else begin
                  state_s = DOWN;
                  cnt_s   = CNT_ZERO;
               end
            end
            default: begin
               state_s = IDLE;
               cnt_s   = CNT_ZERO;
            end
         endcase
      end else begin
         state_s = state_r;
      end
   end

   assign key_code  = key_code_r;
   assign key_valid = key_valid_r;
   assign key_down  = key_down_r;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: strobes the rows of a 4x4 matrix keypad, reads the
// active-low columns and hands one debounced key press at a time to key_if.
//   clk, reset - clock, asynchronous active-high reset
//   col_n      - keypad columns, active-low, asynchronous to clk
//   row_n      - row drive, exactly one bit low at all times
//   key_if     - key_code / key_valid / key_down / multi_key (master side)
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_TICKS     = 50000,
   parameter int unsigned DEBOUNCE_SCANS = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [3:0]               col_n,
   output logic [3:0]               row_n,
   keypad_scanner_if.master         key_if
);

   localparam int unsigned   TW        = $clog2(SCAN_TICKS);
   localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);

   logic [3:0]    col_meta_r, col_sync_r;
   logic [TW-1:0] tick_r;
   logic [1:0]    row_idx_r;
   logic [3:0]    row_n_r;
   logic [1:0]    hit_cnt_r;    // hits so far this scan, saturates at 2
   logic [3:0]    hit_idx_r;    // raw index of the first hit this scan
   logic          multi_key_r;

   logic          sample_s, scan_done_s;
   logic [2:0]    row_hits_s, sum_s;
   logic [1:0]    row_col_s, scan_hits_s;
   logic [3:0]    scan_idx_s;
   scan_res_e     scan_res_s;
   logic [3:0]    key_code_s;
   logic          key_valid_s, key_down_s;

   // Two-flop synchronizer; idle columns read as released
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col_meta_r <= 4'hF;
         col_sync_r <= 4'hF;
      end else begin
         col_meta_r <= col_n;
         col_sync_r <= col_meta_r;
      end
   end

   // Dwell counter and row drive; the row advances on the sample cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tick_r    <= {TW{1'b0}};
         row_idx_r <= 2'd0;
         row_n_r   <= 4'b1110;
      end else if (sample_s) begin
         tick_r    <= {TW{1'b0}};
         row_idx_r <= row_idx_r + 2'd1;
         row_n_r   <= {row_n_r[2:0], row_n_r[3]};
      end else begin
         tick_r    <= tick_r + TW'(1'b1);
      end
   end

   // Hits in the current row merged into the running totals for this scan
   always_comb begin
      row_hits_s = 3'd0;
      row_col_s  = 2'd0;
      for (int c = 0; c < 4; c++) begin
         if (!col_sync_r[c]) begin
            row_hits_s = row_hits_s + 3'd1;
            row_col_s  = 2'(c);
         end else begin
            row_hits_s = row_hits_s;
         end
      end
      sum_s       = {1'b0, hit_cnt_r} + row_hits_s;
      scan_hits_s = (sum_s >= 3'd2) ? 2'd2 : sum_s[1:0];
      scan_idx_s  = (hit_cnt_r == 2'd0) ? {row_idx_r, row_col_s} : hit_idx_r;
      case (scan_hits_s)
         2'd0:    scan_res_s = NONE;
         2'd1:    scan_res_s = SINGLE;
         default: scan_res_s = MULTI;
      endcase
   end

   assign sample_s    = (tick_r == TICK_LAST);
   assign scan_done_s = sample_s && (row_idx_r == 2'd3);

   // Scan accumulator; cleared when the row-3 sample closes the scan
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hit_cnt_r   <= 2'd0;
         hit_idx_r   <= 4'h0;
         multi_key_r <= 1'b0;
      end else if (scan_done_s) begin
         hit_cnt_r   <= 2'd0;
         hit_idx_r   <= 4'h0;
         multi_key_r <= (scan_res_s == MULTI);
      end else if (sample_s) begin
         hit_cnt_r   <= scan_hits_s;
         hit_idx_r   <= scan_idx_s;
      end else begin
         hit_cnt_r   <= hit_cnt_r;
      end
   end

   keypad_debounce #(
      .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
   ) u_debounce (
      .clk       (clk),
      .reset     (reset),
      .scan_done (scan_done_s),
      .scan_res  (scan_res_s),
      .raw_idx   (scan_idx_s),
      .key_code  (key_code_s),
      .key_valid (key_valid_s),
      .key_down  (key_down_s)
   );

   assign row_n            = row_n_r;
   assign key_if.key_code  = key_code_s;
   assign key_if.key_valid = key_valid_s;
   assign key_if.key_down  = key_down_s;
   assign key_if.multi_key = multi_key_r;

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart of the multiplexed seven-segment driver.
- The display driver strobes anodes and drives segments; this block strobes the rows of a 4x4 matrix keypad (Pmod KYPD layout) and reads its columns.
- It resolves a single debounced key press into a 4-bit hex code plus a one-cycle strobe.
- Output feeds the controller/datapath so operands A/B can be keyed in nibble by nibble instead of from switches.

Parameters:
- SCAN_TICKS, 50000: clk cycles each row is driven (0.5 ms at 100 MHz). Legal range >= 4.
- DEBOUNCE_SCANS, 4: consecutive identical full scans required to accept a press or a release. Legal range >= 2.

Ports:
- clk  input  1: system clock.
- reset  input  1: asynchronous, active-high reset.
- col_n  input  4: keypad columns, active-low, externally pulled up, asynchronous to clk.
- row_n  output  4: keypad row drive, active-low, exactly one bit low at all times.
- key_code  output  4: hex label of the last accepted key; held until the next accepted press.
- key_valid  output  1: one-cycle pulse when a press is accepted.
- key_down  output  1: high from acceptance until the release is accepted.
- multi_key  output  1: high while the most recent completed scan saw two or more keys.

Behaviour:
- Reset (asynchronous, on assertion):
  - row_n=4'b1110, key_code=0, key_valid=0, key_down=0, multi_key=0.
  - Column synchronizer flops = 4'hF; tick counter and row index = 0; debounce FSM = IDLE; debounce count = 0.
  - Reset mid-operation clears everything. No key_valid is emitted on reset exit.
- Synchronizer: col_n passes through 2 flops before use.
- Row scan:
  - Tick counter runs 0..SCAN_TICKS-1.
  - On tick==SCAN_TICKS-1: sample the synchronized columns for the current row, then advance the row index (3 wraps to 0).
  - row_n = ~(4'b0001 << row_idx).
  - Full scan = 4 dwells = 4*SCAN_TICKS cycles.
- Scan accumulation: over one full scan, count low column bits across all rows.
  - 0 hits: result NONE.
  - 1 hit: result SINGLE, raw index = row*4+col.
  - 2 or more hits: result MULTI.
  - The result is evaluated on the sample cycle of row 3. multi_key is updated on that cycle.
- Label map, raw index -> hex:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: 0 F E D
- Debounce FSM, evaluated once per scan result:
  - IDLE:
    - SINGLE(c) -> PRESS_CHK with cand=c, cnt=1.
    - NONE or MULTI -> stay in IDLE.
  - PRESS_CHK:
    - SINGLE(cand) -> cnt+1. When cnt reaches DEBOUNCE_SCANS -> DOWN: key_code<=cand, key_valid pulses for that one cycle, key_down<=1.
    - SINGLE(other) -> stay in PRESS_CHK with cand=other, cnt=1.
    - NONE or MULTI -> IDLE, cnt=0.
  - DOWN:
    - NONE -> RELEASE_CHK, cnt=1.
    - SINGLE (any) or MULTI -> stay in DOWN. No roll-over, no repeat strobe.
  - RELEASE_CHK:
    - NONE -> cnt+1. When cnt reaches DEBOUNCE_SCANS -> IDLE, key_down<=0.
    - Any hit -> DOWN, cnt=0. key_valid does not pulse.
- Latency: from a clean, stable press to key_valid is at most (DEBOUNCE_SCANS+1) full scans + 2 cycles.
- key_valid never asserts on two consecutive cycles.
- key_valid never asserts while key_down is already 1.

Decomposition:
- Package keypad_pkg holds:
  - the state enum {IDLE, PRESS_CHK, DOWN, RELEASE_CHK};
  - the scan-result enum {NONE, SINGLE, MULTI};
  - the 16-entry label table as a function key_label(raw[3:0]) returning logic [3:0].
- One sub-module: keypad_debounce. It contains the FSM, the counter and the output registers, takes the scan result and raw index, and produces key_code, key_valid and key_down.
- The scanner top contains the synchronizer, tick counter, row drive and accumulation.

Test Plan:
Bench settings: SCAN_TICKS=4, DEBOUNCE_SCANS=3, so one scan = 16 cycles. Keypad model drives col_n[c]=0 iff row_n[r]==0 and key (r,c) is pressed.
1. Reset, no keys -> row_n cycles 1110,1101,1011,0111, 4 cycles each, repeating; all other outputs stay 0 for 200 cycles.
2. Press (1,2) and hold 300 cycles -> exactly one key_valid pulse within 4 scans + 2 cycles, key_code=4'h6, key_down=1. Release -> key_down falls after 3 empty scans; key_code stays 6.
3. Bounce: press (3,0) present and absent on alternating scans for 10 scans -> no key_valid, key_down stays 0. Then hold steady -> one pulse, key_code=4'h0.
4. Press (0,0) and (0,3) together -> multi_key=1 after first full scan, no key_valid. Release (0,3) -> multi_key=0, one pulse with key_code=4'h1.
5. Hold (2,3) until key_down=1, then add (1,1) -> no new pulse, key_code stays 4'hC. Release both -> key_down=0 after 3 empty scans.
6. Assert reset while key_down=1 with (3,1) still held -> outputs cleared immediately. After deassertion -> a fresh acceptance with key_code=4'hF after 3 scans.
